span_walker_s11: RTL



---
 rtl/span_walker_s11_if.sv | 33 +++
 rtl/span_walker_s11.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/span_walker_s11_if.sv
// Span request / pixel stream bundle for span_walker_s11.
// The slave modport is the walker itself; master is whoever issues spans
// and consumes pixels.
interface span_walker_s11_if #(
  parameter int CNT_W = 12
);
  logic                     start;
  logic signed [10:0]       x0;
  logic signed [10:0]       x1;
  logic signed [10:0]       y;
  logic signed [10:0]       clip_l;
  logic signed [10:0]       clip_r;
  logic signed [10:0]       clip_t;
  logic signed [10:0]       clip_b;
  logic                     busy;
  logic                     pix_valid;
  logic                     pix_ready;
  logic signed [10:0]       pix_x;
  logic signed [10:0]       pix_y;
  logic                     pix_last;
  logic                     done;
  logic [CNT_W-1:0]         pix_count;

  modport master (
    output start, x0, x1, y, clip_l, clip_r, clip_t, clip_b, pix_ready,
    input  busy, pix_valid, pix_x, pix_y, pix_last, done, pix_count
  );

  modport slave (
    input  start, x0, x1, y, clip_l, clip_r, clip_t, clip_b, pix_ready,
    output busy, pix_valid, pix_x, pix_y, pix_last, done, pix_count
  );
endinterface

// File: rtl/span_walker_s11.sv
// Scanline span walker: clips one horizontal span against the drawing
// area and emits the surviving pixels one per accepted beat, walking from
// the clipped start toward the clipped end. Empty spans produce only a
// done pulse.
module span_walker_s11 #(
  parameter int CNT_W = 12
) (
  input  logic              m_clock,
  input  logic              p_reset,
  span_walker_s11_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLAMP = 2'd1,
    WALK  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Span parameters captured at start; held for the whole span.
  logic signed [10:0] x0_q;
  logic signed [10:0] x1_q;
  logic signed [10:0] y_q;
  logic signed [10:0] cl_q;
  logic signed [10:0] cr_q;
  logic signed [10:0] ct_q;
  logic signed [10:0] cb_q;

  // Walk state: cur doubles as the pix_x register.
  logic signed [10:0] cur;
  logic signed [10:0] xe_q;
  logic               dir_neg;

  // Registered outputs.
  logic               busy_q;
  logic               valid_q;
  logic               last_q;
  logic               done_q;
  logic signed [10:0] pix_y_q;
  logic [CNT_W-1:0]   cnt_q;

  // Clip results evaluated from the latched span during CLAMP.
  logic               desc;
  logic signed [10:0] xs;
  logic signed [10:0] xe;
  logic               y_out;
  logic               x_empty;
  logic               span_empty;
  logic signed [10:0] cur_nxt;
  logic               accept;

  function automatic logic signed [10:0] smax(input logic signed [10:0] a,
                                              input logic signed [10:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [10:0] smin(input logic signed [10:0] a,
                                              input logic signed [10:0] b);
    return (a < b) ? a : b;
  endfunction

  // Clip window and next walk position. cur only advances while cur != xe,
  // so cur_nxt always stays inside [xs, xe] and cannot wrap.
  always_comb begin
    desc       = (x1_q < x0_q);
    xs         = desc ? smin(x0_q, cr_q) : smax(x0_q, cl_q);
    xe         = desc ? smax(x1_q, cl_q) : smin(x1_q, cr_q);
    y_out      = (y_q < ct_q) || (y_q > cb_q);
    x_empty    = desc ? (xs < xe) : (xs > xe);
    span_empty = y_out || x_empty;
    cur_nxt    = dir_neg ? (cur - 11'sd1) : (cur + 11'sd1);
    accept     = valid_q && bus.pix_ready;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      cur     <= '0;
      pix_y_q <= '0;
      cnt_q   <= '0;
      dir_neg <= 1'b0;
      xe_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
            state  <= CLAMP;
          end
        end
        CLAMP: begin
          dir_neg <= desc;
          xe_q    <= xe;
          if (span_empty) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            cur     <= xs;
            pix_y_q <= y_q;
            last_q  <= (xs == xe);
            valid_q <= 1'b1;
            state   <= WALK;
          end
        end
        WALK: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end else begin
              cur    <= cur_nxt;
              last_q <= (cur_nxt == xe_q);
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Span capture; only meaningful while idle, so no reset needed.
  always_ff @(posedge m_clock) begin
    if (state == IDLE && bus.start) begin
      x0_q <= bus.x0;
      x1_q <= bus.x1;
      y_q  <= bus.y;
      cl_q <= bus.clip_l;
      cr_q <= bus.clip_r;
      ct_q <= bus.clip_t;
      cb_q <= bus.clip_b;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.pix_valid = valid_q;
  assign bus.pix_x     = cur;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_last  = last_q;
  assign bus.done      = done_q;
  assign bus.pix_count = cnt_q;

endmodule
